// File: rtl/jk_bank_sequencer.sv
// Steps a bank of external JK flip-flops from its current state to a target word.
// Each step changes at most STEP_BITS bits. The bank's q outputs are checked after every step.
//
// state  | meaning
// IDLE   | waiting for a target word; tgt_ready high
// SYNC   | copy q_fb into shadow; skip to DONE if the bank already matches
// DRIVE  | j/k hold the set/reset commands for this step
// SETTLE | j/k idle; compare the bank against shadow
// DONE   | one-cycle done pulse
module jk_bank_sequencer #(
  parameter int WIDTH     = 8,
  parameter int STEP_BITS = 1,
  parameter int CHECK_EN  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             err_clr
);

  typedef enum logic [2:0] {IDLE, SYNC, DRIVE, SETTLE, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] target, shadow;
  logic [WIDTH-1:0] cmd_base, diff, sel;
  logic [WIDTH-1:0] j_nxt, k_nxt;
  logic             settle_mismatch;
  int               sel_cnt;

  // j/k are registered, so the commands for a DRIVE cycle are chosen one cycle
  // earlier: from q_fb when leaving SYNC (shadow not loaded yet), else from shadow.
  always_comb begin
    cmd_base = (state == SYNC) ? q_fb : shadow;
    diff     = cmd_base ^ target;
    sel      = '0;
    sel_cnt  = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (diff[i] && (sel_cnt < STEP_BITS)) begin
        sel[i]  = 1'b1;
        sel_cnt = sel_cnt + 1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    j_nxt     = '0;
    k_nxt     = '0;
    case (state)
      IDLE:    if (tgt_valid) state_nxt = SYNC;
      SYNC:    state_nxt = (q_fb == target) ? DONE : DRIVE;
      DRIVE:   state_nxt = SETTLE;
      SETTLE:  state_nxt = (shadow == target) ? DONE : DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == DRIVE) begin
      j_nxt = sel & target;
      k_nxt = sel & ~target;
    end
  end

  assign settle_mismatch = (CHECK_EN != 0) && (state == SETTLE) && (q_fb != shadow);

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      j      <= '0;
      k      <= '0;
      err    <= 1'b0;
      target <= '0;
      shadow <= '0;
    end else begin
      state <= state_nxt;
      j     <= j_nxt;
      k     <= k_nxt;
      if (state == IDLE && tgt_valid) target <= tgt_data;
      // Selected bits always differ from shadow, so applying a step is a flip.
      if (state == SYNC)       shadow <= q_fb;
      else if (state == DRIVE) shadow <= shadow ^ (j | k);
      if (settle_mismatch)     err <= 1'b1;
      else if (err_clr)        err <= 1'b0;
    end
  end

  assign tgt_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Scoreboard bench for jk_bank_sequencer: two instances (STEP_BITS 1 and 2), each
// driving a behavioural JK bank model with an optional stuck-at-0 mask.
module tb_jk_bank_sequencer;

  typedef struct { logic [7:0] j; logic [7:0] k; } cmd_t;
  typedef struct { logic [7:0] bank; logic err; int lat; } dn_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       err_clr;
  logic       vld     [2];
  logic [7:0] dat     [2];
  logic       rdy     [2];
  logic [7:0] bank    [2];
  logic [7:0] j_s     [2];
  logic [7:0] k_s     [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       err_s   [2];
  logic       ld      [2];
  logic [7:0] ld_val  [2];
  logic [7:0] stuck   [2];

  cmd_t exp_cmd [2][$];
  dn_t  exp_dn  [2][$];
  int   acc_cyc [2];
  int   acc_cnt [2];
  int   ncyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  jk_bank_sequencer #(.WIDTH(8), .STEP_BITS(1), .CHECK_EN(1)) dut0 (
    .clock(clock), .reset(reset), .tgt_valid(vld[0]), .tgt_ready(rdy[0]),
    .tgt_data(dat[0]), .q_fb(bank[0]), .j(j_s[0]), .k(k_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .err(err_s[0]), .err_clr(err_clr));

  jk_bank_sequencer #(.WIDTH(8), .STEP_BITS(2), .CHECK_EN(1)) dut1 (
    .clock(clock), .reset(reset), .tgt_valid(vld[1]), .tgt_ready(rdy[1]),
    .tgt_data(dat[1]), .q_fb(bank[1]), .j(j_s[1]), .k(k_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .err(err_s[1]), .err_clr(err_clr));

  function automatic logic [7:0] jk_next(logic [7:0] q, logic [7:0] jj, logic [7:0] kk);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      case ({jj[i], kk[i]})
        2'b10:   r[i] = 1'b1;
        2'b01:   r[i] = 1'b0;
        2'b11:   r[i] = ~q[i];
        default: r[i] = q[i];
      endcase
    end
    return r;
  endfunction

  always @(posedge clock) begin
    for (int n = 0; n < 2; n++) begin
      if (ld[n]) bank[n] <= ld_val[n] & ~stuck[n];
      else       bank[n] <= jk_next(bank[n], j_s[n], k_s[n]) & ~stuck[n];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic mon(input int id);
    cmd_t c;
    dn_t  e;
    if (vld[id] && rdy[id]) begin
      acc_cyc[id] = ncyc;
      acc_cnt[id]++;
    end
    if ((j_s[id] | k_s[id]) != 8'h00) begin
      check($sformatf("dut%0d j&k overlap", id), {24'h0, j_s[id] & k_s[id]}, 32'h0);
      if (exp_cmd[id].size() == 0) begin
        check($sformatf("dut%0d unexpected cmd j/k", id), {16'h0, j_s[id], k_s[id]}, 32'h0);
      end else begin
        c = exp_cmd[id].pop_front();
        check($sformatf("dut%0d cmd j", id), {24'h0, j_s[id]}, {24'h0, c.j});
        check($sformatf("dut%0d cmd k", id), {24'h0, k_s[id]}, {24'h0, c.k});
      end
    end
    if (done_s[id]) begin
      if (exp_dn[id].size() == 0) begin
        check($sformatf("dut%0d unexpected done", id), 32'h1, 32'h0);
      end else begin
        e = exp_dn[id].pop_front();
        check($sformatf("dut%0d bank at done", id), {24'h0, bank[id]}, {24'h0, e.bank});
        check($sformatf("dut%0d err at done", id), {31'h0, err_s[id]}, {31'h0, e.err});
        check($sformatf("dut%0d done latency", id), ncyc - acc_cyc[id], e.lat);
      end
    end
  endtask

  always @(negedge clock) begin
    mon(0);
    mon(1);
    ncyc++;
  end

  task automatic push_cmd(input int id, input logic [7:0] jj, input logic [7:0] kk);
    cmd_t c;
    c.j = jj;
    c.k = kk;
    exp_cmd[id].push_back(c);
  endtask

  task automatic push_dn(input int id, input logic [7:0] b, input logic e, input int lat);
    dn_t d;
    d.bank = b;
    d.err  = e;
    d.lat  = lat;
    exp_dn[id].push_back(d);
  endtask

  task automatic load_bank(input int id, input logic [7:0] init, input logic [7:0] stuck_m);
    stuck[id]  = stuck_m;
    ld[id]     = 1'b1;
    ld_val[id] = init;
    @(posedge clock); #2;
    ld[id] = 1'b0;
  endtask

  task automatic wait_done(input int id);
    for (int c = 0; c < 60 && exp_dn[id].size() != 0; c++) begin
      @(posedge clock); #2;
    end
    check($sformatf("dut%0d pending done (timeout)", id), exp_dn[id].size(), 0);
    check($sformatf("dut%0d pending cmds", id), exp_cmd[id].size(), 0);
  endtask

  task automatic run(input int id, input logic [7:0] init, input logic [7:0] tgt,
                     input logic [7:0] stuck_m, input logic [7:0] exp_bank,
                     input logic exp_err, input int lat);
    load_bank(id, init, stuck_m);
    push_dn(id, exp_bank, exp_err, lat);
    vld[id] = 1'b1;
    dat[id] = tgt;
    @(posedge clock); #2;
    vld[id] = 1'b0;
    wait_done(id);
  endtask

  initial begin
    int acc0;
    reset   = 1'b1;
    err_clr = 1'b0;
    for (int n = 0; n < 2; n++) begin
      vld[n] = 1'b0; dat[n] = 8'h00; ld[n] = 1'b0; ld_val[n] = 8'h00;
      stuck[n] = 8'h00; acc_cyc[n] = 0; acc_cnt[n] = 0;
    end
    repeat (2) begin @(posedge clock); #2; end
    check("reset j", {24'h0, j_s[0]}, 32'h0);
    check("reset k", {24'h0, k_s[0]}, 32'h0);
    check("reset tgt_ready", {31'h0, rdy[0]}, 32'h1);
    check("reset busy", {31'h0, busy_s[0]}, 32'h0);
    check("reset done", {31'h0, done_s[0]}, 32'h0);
    check("reset err", {31'h0, err_s[0]}, 32'h0);
    check("reset tgt_ready dut1", {31'h0, rdy[1]}, 32'h1);
    reset = 1'b0;
    @(posedge clock); #2;

    // 0x00 -> 0x05, one bit per step
    push_cmd(0, 8'h01, 8'h00);
    push_cmd(0, 8'h04, 8'h00);
    run(0, 8'h00, 8'h05, 8'h00, 8'h05, 1'b0, 6);

    // already at target: no commands, done two cycles after accept
    run(0, 8'hA5, 8'hA5, 8'h00, 8'hA5, 1'b0, 2);

    // 0x3C -> 0xC3: all bits differ, eight single-bit steps
    push_cmd(0, 8'h01, 8'h00);
    push_cmd(0, 8'h02, 8'h00);
    push_cmd(0, 8'h00, 8'h04);
    push_cmd(0, 8'h00, 8'h08);
    push_cmd(0, 8'h00, 8'h10);
    push_cmd(0, 8'h00, 8'h20);
    push_cmd(0, 8'h40, 8'h00);
    push_cmd(0, 8'h80, 8'h00);
    run(0, 8'h3C, 8'hC3, 8'h00, 8'hC3, 1'b0, 18);

    // two bits per step: 0xFF -> 0x0F and 0x00 -> 0x07
    push_cmd(1, 8'h00, 8'h30);
    push_cmd(1, 8'h00, 8'hC0);
    run(1, 8'hFF, 8'h0F, 8'h00, 8'h0F, 1'b0, 6);
    push_cmd(1, 8'h03, 8'h00);
    push_cmd(1, 8'h04, 8'h00);
    run(1, 8'h00, 8'h07, 8'h00, 8'h07, 1'b0, 6);

    // bank bit 2 stuck at 0: err sets, sequence still completes
    push_cmd(0, 8'h04, 8'h00);
    run(0, 8'h00, 8'h04, 8'h04, 8'h00, 1'b1, 4);
    repeat (3) begin @(posedge clock); #2; end
    check("err sticky", {31'h0, err_s[0]}, 32'h1);
    err_clr = 1'b1;
    @(posedge clock); #2;
    err_clr = 1'b0;
    check("err cleared", {31'h0, err_s[0]}, 32'h0);

    // tgt_valid held high with changing data while busy: exactly one accept
    load_bank(0, 8'h00, 8'h00);
    push_cmd(0, 8'h01, 8'h00);
    push_cmd(0, 8'h04, 8'h00);
    push_dn(0, 8'h05, 1'b0, 6);
    acc0 = acc_cnt[0];
    vld[0] = 1'b1;
    dat[0] = 8'h05;
    @(posedge clock); #2;
    dat[0] = 8'hFF;
    repeat (5) begin @(posedge clock); #2; end
    vld[0] = 1'b0;
    wait_done(0);
    check("single accept while busy", acc_cnt[0] - acc0, 1);

    // reset during DRIVE aborts: IDLE next cycle, j=k=0, no done
    load_bank(0, 8'h00, 8'h00);
    push_cmd(0, 8'h80, 8'h00);
    vld[0] = 1'b1;
    dat[0] = 8'h80;
    @(posedge clock); #2;
    vld[0] = 1'b0;
    @(posedge clock); #2;
    reset = 1'b1;
    @(posedge clock); #2;
    reset = 1'b0;
    check("abort j", {24'h0, j_s[0]}, 32'h0);
    check("abort k", {24'h0, k_s[0]}, 32'h0);
    check("abort tgt_ready", {31'h0, rdy[0]}, 32'h1);
    check("abort busy", {31'h0, busy_s[0]}, 32'h0);
    check("abort done", {31'h0, done_s[0]}, 32'h0);
    repeat (8) begin @(posedge clock); #2; end
    check("abort cmds consumed", exp_cmd[0].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
